endp_reg_bank: RTL and testbench
================================

Name: endp_reg_bank

Overview:
- Parametrised successor to the single-bit left/right endpoint register pair.
- Holds CHANNELS independent pairs of WIDTH-bit registers (L, R) and applies set/xor/swap/clear instructions through a valid/ready handshake.
- Exposes every pair, a registered L^R readback and a change-notification pulse.
- Sits between the instruction decoder and the xor-chain datapath.

Parameters:
- WIDTH, 8, bits per L/R register (>=1).
- CHANNELS, 4, number of L/R pairs (>=1).
- CH_W, max(1,$clog2(CHANNELS)), width of channel-index ports (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction present.
- in_ready  out  1  block can accept an instruction this cycle.
- inst  in  3  opcode.
- ch  in  CH_W  target channel.
- din  in  WIDTH  operand (ztonxor generalised).
- q_l  out  CHANNELS*WIDTH  all L registers, channel k at [k*WIDTH +: WIDTH].
- q_r  out  CHANNELS*WIDTH  all R registers, same packing.
- rd_ch  in  CH_W  readback channel select.
- ltor_xor  out  WIDTH  registered L^R of channel rd_ch.
- chg_valid  out  1  one-cycle pulse: accepted op changed L^R of its channel.
- chg_ch  out  CH_W  channel associated with chg_valid.
- err  out  1  one-cycle pulse: op rejected (ch >= CHANNELS).
- busy  out  1  CLRALL sweep in progress.

Behaviour:
- Reset (reset=0, async): all L/R=0, ltor_xor=0, chg_valid=0, chg_ch=0, err=0, busy=0, state=IDLE, sweep index=0. in_ready=1 once reset deasserts.
- Accept = in_valid & in_ready. Effect on q_l/q_r is visible after the accepting edge (1-cycle latency).
- Opcodes:
  - 000 NOP: no effect.
  - 001 SETL: L<=din.
  - 010 SETR: R<=din.
  - 011 SETB: L<=din and R<=din.
  - 100 XORL: L<=L^din.
  - 101 XORR: R<=R^din.
  - 110 SWAP: L<=R and R<=L, same edge.
  - 111 CLRALL: start sweep; ch and din ignored.
- Unaccepted cycles: all registers hold (equivalent of !isSET & q).
- ch >= CHANNELS on any opcode except NOP/CLRALL: no state change; err=1 for the cycle after acceptance.
- chg_valid/chg_ch: registered from the accepted op. chg_valid=1 on the cycle after the edge iff new L^R != old L^R for that channel.
  - Consequences: SWAP and SETB-from-equal never pulse; SETB always yields L^R=0.
- ltor_xor: registered each cycle from the current q_l/q_r of rd_ch, so it lags q by one cycle. rd_ch is sampled every cycle, including during the sweep.
- FSM:
  - IDLE: in_ready=1, busy=0. Accepted CLRALL -> SWEEP with idx=0.
  - SWEEP: in_ready=0, busy=1. Each cycle clears L[idx] and R[idx], then idx++. The edge clearing idx=CHANNELS-1 returns the FSM to IDLE.
  - Sweep length is exactly CHANNELS cycles. in_ready is high again CHANNELS cycles after the accept edge.
- Sweep notifications: during SWEEP, chg_valid pulses per cleared channel whose L^R was nonzero, with chg_ch=idx.
- in_valid held during SWEEP: ignored, not queued. The source must hold it until in_ready.
- Reset mid-sweep: immediate return to IDLE with all registers zero.
- Arithmetic: pure bitwise operations, no carries, no width growth.

Optional Feature:
- Macro: ENDP_REG_BANK_PARITY_EN.
- Defined: adds output ltor_par (1 bit) = ^ltor_xor, registered together with ltor_xor. Reset value 0.
- Defined: err also pulses for an accepted op whose din has odd parity when inst=SETB; that op is still executed.
- Undefined: no ltor_par port; err only covers the channel-range check.

Test Plan:
- Reset, then SETL ch1 din=0xA5, then SETR ch1 din=0x0F, rd_ch=1 -> q_l[15:8]=0xA5, q_r[15:8]=0x0F. ltor_xor=0xAA one cycle after q updates. chg_valid pulses with chg_ch=1 after each op.
- XORL ch2 din=0xFF twice -> L2=0xFF, then 0x00. Two chg_valid pulses, chg_ch=2.
- Set ch3 L=0x12, R=0x34, then SWAP -> L3=0x34, R3=0x12, no chg_valid. SETB ch3 din=0x55 -> L3=R3=0x55, chg_valid=1.
- CHANNELS=4, channels 0 and 2 nonzero, CLRALL -> busy=1 and in_ready=0 for exactly 4 cycles, all q zero afterwards. chg_valid pulses with chg_ch=0, then 2. SETL offered during the sweep is ignored.
- CHANNELS=3, SETL ch=3 -> err pulse, no register change. Reset asserted 2 cycles into a sweep -> all outputs at reset values, busy=0 immediately.

Source files
------------

// File: rtl/endp_reg_bank.sv
// Bank of CHANNELS left/right WIDTH-bit register pairs with set/xor/swap/clear-all ops.
// Optional ENDP_REG_BANK_PARITY_EN adds ltor_par and odd-parity SETB error reporting.
module endp_reg_bank #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    localparam int unsigned CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2:0]                inst,
    input  logic [CH_W-1:0]           ch,
    input  logic [WIDTH-1:0]          din,
    output logic [CHANNELS*WIDTH-1:0] q_l,
    output logic [CHANNELS*WIDTH-1:0] q_r,
    input  logic [CH_W-1:0]           rd_ch,
    output logic [WIDTH-1:0]          ltor_xor,
    output logic                      chg_valid,
    output logic [CH_W-1:0]           chg_ch,
    output logic                      err,
    output logic                      busy
`ifdef ENDP_REG_BANK_PARITY_EN
    ,
    output logic                      ltor_par
`endif
);

    localparam logic [2:0] OP_NOP    = 3'b000;
    localparam logic [2:0] OP_SETL   = 3'b001;
    localparam logic [2:0] OP_SETR   = 3'b010;
    localparam logic [2:0] OP_SETB   = 3'b011;
    localparam logic [2:0] OP_XORL   = 3'b100;
    localparam logic [2:0] OP_XORR   = 3'b101;
    localparam logic [2:0] OP_SWAP   = 3'b110;
    localparam logic [2:0] OP_CLRALL = 3'b111;

    typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  l_q [CHANNELS];
    logic [WIDTH-1:0]  l_d [CHANNELS];
    logic [WIDTH-1:0]  r_q [CHANNELS];
    logic [WIDTH-1:0]  r_d [CHANNELS];
    logic [WIDTH-1:0]  ltor_xor_q, ltor_xor_d;
    logic              chg_valid_q, chg_valid_d;
    logic [CH_W-1:0]   chg_ch_q, chg_ch_d;
    logic              err_q, err_d;
    logic [WIDTH-1:0]  nl, nr;
    logic              ch_ok;

    assign ch_ok = 32'(ch) < CHANNELS;

    // Next-state: instruction decode in IDLE, one channel cleared per cycle in SWEEP.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        l_d         = l_q;
        r_d         = r_q;
        chg_valid_d = 1'b0;
        chg_ch_d    = chg_ch_q;
        err_d       = 1'b0;
        nl          = '0;
        nr          = '0;
        ltor_xor_d  = '0;

        for (int k = 0; k < int'(CHANNELS); k++) begin
            if (rd_ch == CH_W'(k)) ltor_xor_d = l_q[k] ^ r_q[k];
        end

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (inst == OP_CLRALL) begin
                        state_d = SWEEP;
                        idx_d   = '0;
                    end else if (inst != OP_NOP) begin
                        if (!ch_ok) err_d = 1'b1;
                        for (int k = 0; k < int'(CHANNELS); k++) begin
                            if (ch_ok && ch == CH_W'(k)) begin
                                nl = l_q[k];
                                nr = r_q[k];
                                case (inst)
                                    OP_SETL: nl = din;
                                    OP_SETR: nr = din;
                                    OP_SETB: begin nl = din; nr = din; end
                                    OP_XORL: nl = l_q[k] ^ din;
                                    OP_XORR: nr = r_q[k] ^ din;
                                    OP_SWAP: begin nl = r_q[k]; nr = l_q[k]; end
                                    default: ;
                                endcase
                                l_d[k]      = nl;
                                r_d[k]      = nr;
                                chg_valid_d = (nl ^ nr) != (l_q[k] ^ r_q[k]);
                                chg_ch_d    = ch;
                            end
                        end
`ifdef ENDP_REG_BANK_PARITY_EN
                        if (inst == OP_SETB && (^din)) err_d = 1'b1;
`endif
                    end
                end
            end
            SWEEP: begin
                for (int k = 0; k < int'(CHANNELS); k++) begin
                    if (idx_q == CH_W'(k)) begin
                        chg_valid_d = (l_q[k] ^ r_q[k]) != '0;
                        chg_ch_d    = idx_q;
                        l_d[k]      = '0;
                        r_d[k]      = '0;
                    end
                end
                if (32'(idx_q) == CHANNELS - 1) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + CH_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            ltor_xor_q  <= '0;
            chg_valid_q <= 1'b0;
            chg_ch_q    <= '0;
            err_q       <= 1'b0;
            for (int k = 0; k < int'(CHANNELS); k++) begin
                l_q[k] <= '0;
                r_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            ltor_xor_q  <= ltor_xor_d;
            chg_valid_q <= chg_valid_d;
            chg_ch_q    <= chg_ch_d;
            err_q       <= err_d;
            l_q         <= l_d;
            r_q         <= r_d;
        end
    end

`ifdef ENDP_REG_BANK_PARITY_EN
    logic ltor_par_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ltor_par_q <= 1'b0;
        else        ltor_par_q <= ^ltor_xor_d;
    end
    assign ltor_par = ltor_par_q;
`endif

    always_comb begin
        q_l = '0;
        q_r = '0;
        for (int k = 0; k < int'(CHANNELS); k++) begin
            q_l[k*WIDTH +: WIDTH] = l_q[k];
            q_r[k*WIDTH +: WIDTH] = r_q[k];
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == SWEEP);
    assign ltor_xor  = ltor_xor_q;
    assign chg_valid = chg_valid_q;
    assign chg_ch    = chg_ch_q;
    assign err       = err_q;

endmodule

// File: tb/tb_endp_reg_bank.sv
// Randomized self-checking bench for endp_reg_bank against a per-channel L/R array model.
module tb_endp_reg_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        in_valid, in_ready;
    logic [2:0]  inst;
    logic [1:0]  ch, rd_ch, chg_ch;
    logic [7:0]  din, ltor_xor;
    logic [31:0] q_l, q_r;
    logic        chg_valid, err, busy;

    logic        in_valid3, in_ready3;
    logic [2:0]  inst3;
    logic [1:0]  ch3, rd_ch3, chg_ch3;
    logic [7:0]  din3, ltor_xor3;
    logic [23:0] q_l3, q_r3;
    logic        chg_valid3, err3, busy3;
`ifdef ENDP_REG_BANK_PARITY_EN
    logic        ltor_par, ltor_par3;
`endif

    endp_reg_bank #(.WIDTH(8), .CHANNELS(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .inst(inst), .ch(ch), .din(din), .q_l(q_l), .q_r(q_r), .rd_ch(rd_ch),
        .ltor_xor(ltor_xor), .chg_valid(chg_valid), .chg_ch(chg_ch), .err(err),
        .busy(busy)
`ifdef ENDP_REG_BANK_PARITY_EN
        , .ltor_par(ltor_par)
`endif
    );

    endp_reg_bank #(.WIDTH(8), .CHANNELS(3)) dut3 (
        .clk(clk), .reset(reset), .in_valid(in_valid3), .in_ready(in_ready3),
        .inst(inst3), .ch(ch3), .din(din3), .q_l(q_l3), .q_r(q_r3), .rd_ch(rd_ch3),
        .ltor_xor(ltor_xor3), .chg_valid(chg_valid3), .chg_ch(chg_ch3), .err(err3),
        .busy(busy3)
`ifdef ENDP_REG_BANK_PARITY_EN
        , .ltor_par(ltor_par3)
`endif
    );

    int tests = 0;
    int fails = 0;

    logic [7:0] ml [4];
    logic [7:0] mr [4];

    function automatic logic [31:0] pack_l();
        logic [31:0] v;
        for (int k = 0; k < 4; k++) v[k*8 +: 8] = ml[k];
        return v;
    endfunction

    function automatic logic [31:0] pack_r();
        logic [31:0] v;
        for (int k = 0; k < 4; k++) v[k*8 +: 8] = mr[k];
        return v;
    endfunction

    // Reference semantics of one accepted op on an in-range channel.
    task automatic model_apply(input logic [2:0] op, input logic [1:0] c, input logic [7:0] d,
                               output logic exp_chg);
        logic [7:0] old_x, t;
        old_x = ml[c] ^ mr[c];
        case (op)
            3'd1: ml[c] = d;
            3'd2: mr[c] = d;
            3'd3: begin ml[c] = d; mr[c] = d; end
            3'd4: ml[c] = ml[c] ^ d;
            3'd5: mr[c] = mr[c] ^ d;
            3'd6: begin t = ml[c]; ml[c] = mr[c]; mr[c] = t; end
            default: ;
        endcase
        exp_chg = (ml[c] ^ mr[c]) != old_x;
    endtask

    function automatic logic exp_err_of(input logic [2:0] op, input logic [7:0] d);
`ifdef ENDP_REG_BANK_PARITY_EN
        return (op == 3'd3) && (^d);
`else
        return 1'b0 & op[0] & d[0];
`endif
    endfunction

    task automatic send(input logic [2:0] op, input logic [1:0] c, input logic [7:0] d,
                        input logic [1:0] rd);
        @(negedge clk);
        in_valid = 1'b1; inst = op; ch = c; din = d; rd_ch = rd;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send3(input logic [2:0] op, input logic [1:0] c, input logic [7:0] d);
        @(negedge clk);
        in_valid3 = 1'b1; inst3 = op; ch3 = c; din3 = d;
        @(posedge clk);
        #1;
        in_valid3 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (q_l !== 32'h0 || q_r !== 32'h0) begin
            fails++; $display("FAIL reset_q: q_l=%h q_r=%h expected 0", q_l, q_r);
        end
        tests++;
        if (ltor_xor !== 8'h0 || chg_valid !== 1'b0 || chg_ch !== 2'd0 || err !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL reset_outs: ltor=%h chg=%b chg_ch=%0d err=%b busy=%b expected all 0",
                              ltor_xor, chg_valid, chg_ch, err, busy);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL reset_ready: in_ready=%b expected 1", in_ready);
        end
        for (int k = 0; k < 4; k++) begin ml[k] = 8'h0; mr[k] = 8'h0; end
    endtask

    task automatic test_set_readback();
        logic ec;
        model_apply(3'd1, 2'd1, 8'hA5, ec);
        send(3'd1, 2'd1, 8'hA5, 2'd1);
        tests++;
        if (q_l[15:8] !== 8'hA5 || chg_valid !== 1'b1 || chg_ch !== 2'd1) begin
            fails++; $display("FAIL setl: L1=%h chg=%b chg_ch=%0d expected A5 1 1", q_l[15:8], chg_valid, chg_ch);
        end
        model_apply(3'd2, 2'd1, 8'h0F, ec);
        send(3'd2, 2'd1, 8'h0F, 2'd1);
        tests++;
        if (q_r[15:8] !== 8'h0F || chg_valid !== 1'b1 || chg_ch !== 2'd1 || ltor_xor !== 8'hA5) begin
            fails++; $display("FAIL setr: R1=%h chg=%b chg_ch=%0d ltor=%h expected 0F 1 1 A5",
                              q_r[15:8], chg_valid, chg_ch, ltor_xor);
        end
        @(posedge clk);
        #1;
        tests++;
        if (ltor_xor !== 8'hAA || chg_valid !== 1'b0) begin
            fails++; $display("FAIL ltor_lag: ltor=%h chg=%b expected AA 0", ltor_xor, chg_valid);
        end
    endtask

    task automatic test_xorl();
        logic ec;
        for (int i = 0; i < 2; i++) begin
            model_apply(3'd4, 2'd2, 8'hFF, ec);
            send(3'd4, 2'd2, 8'hFF, 2'd2);
            tests++;
            if (q_l[23:16] !== ml[2] || chg_valid !== 1'b1 || chg_ch !== 2'd2) begin
                fails++; $display("FAIL xorl%0d: L2=%h chg=%b chg_ch=%0d expected %h 1 2",
                                  i, q_l[23:16], chg_valid, chg_ch, ml[2]);
            end
        end
    endtask

    task automatic test_swap_setb();
        logic ec;
        model_apply(3'd1, 2'd3, 8'h12, ec); send(3'd1, 2'd3, 8'h12, 2'd0);
        model_apply(3'd2, 2'd3, 8'h34, ec); send(3'd2, 2'd3, 8'h34, 2'd0);
        model_apply(3'd6, 2'd3, 8'h00, ec); send(3'd6, 2'd3, 8'h00, 2'd0);
        tests++;
        if (q_l[31:24] !== 8'h34 || q_r[31:24] !== 8'h12 || chg_valid !== 1'b0) begin
            fails++; $display("FAIL swap: L3=%h R3=%h chg=%b expected 34 12 0", q_l[31:24], q_r[31:24], chg_valid);
        end
        model_apply(3'd3, 2'd3, 8'h55, ec); send(3'd3, 2'd3, 8'h55, 2'd0);
        tests++;
        if (q_l[31:24] !== 8'h55 || q_r[31:24] !== 8'h55 || chg_valid !== 1'b1 || chg_ch !== 2'd3) begin
            fails++; $display("FAIL setb: L3=%h R3=%h chg=%b expected 55 55 1", q_l[31:24], q_r[31:24], chg_valid);
        end
    endtask

    task automatic test_random();
        logic [2:0] op; logic [1:0] c, rd; logic [7:0] d, exp_ltor; logic ec;
        for (int i = 0; i < 300; i++) begin
            op = 3'($urandom_range(0, 6));
            c  = 2'($urandom_range(0, 3));
            d  = 8'($urandom);
            rd = 2'($urandom_range(0, 3));
            exp_ltor = ml[rd] ^ mr[rd];
            model_apply(op, c, d, ec);
            send(op, c, d, rd);
            tests++;
            if (q_l !== pack_l() || q_r !== pack_r()) begin
                fails++; $display("FAIL rand_q[%0d] op=%0d: q_l=%h q_r=%h expected %h %h",
                                  i, op, q_l, q_r, pack_l(), pack_r());
            end
            tests++;
            if (chg_valid !== ec || (ec && chg_ch !== c)) begin
                fails++; $display("FAIL rand_chg[%0d] op=%0d: chg=%b chg_ch=%0d expected %b %0d",
                                  i, op, chg_valid, chg_ch, ec, c);
            end
            tests++;
            if (ltor_xor !== exp_ltor || err !== exp_err_of(op, d)) begin
                fails++; $display("FAIL rand_ltor[%0d]: ltor=%h err=%b expected %h %b",
                                  i, ltor_xor, err, exp_ltor, exp_err_of(op, d));
            end
`ifdef ENDP_REG_BANK_PARITY_EN
            tests++;
            if (ltor_par !== (^exp_ltor)) begin
                fails++; $display("FAIL rand_par[%0d]: par=%b expected %b", i, ltor_par, ^exp_ltor);
            end
`endif
        end
    endtask

    task automatic test_clrall();
        logic ec; logic [3:0] exp_pulse; int busy_cycles;
        for (int k = 0; k < 4; k++) begin
            model_apply(3'd3, 2'(k), 8'h00, ec); send(3'd3, 2'(k), 8'h00, 2'd0);
        end
        model_apply(3'd1, 2'd0, 8'h11, ec); send(3'd1, 2'd0, 8'h11, 2'd0);
        model_apply(3'd2, 2'd2, 8'h22, ec); send(3'd2, 2'd2, 8'h22, 2'd0);
        for (int k = 0; k < 4; k++) exp_pulse[k] = (ml[k] ^ mr[k]) != 8'h00;
        send(3'd7, 2'd1, 8'hFF, 2'd0);
        busy_cycles = 0;
        tests++;
        if (busy !== 1'b1 || in_ready !== 1'b0 || chg_valid !== 1'b0) begin
            fails++; $display("FAIL clr_start: busy=%b in_ready=%b chg=%b expected 1 0 0", busy, in_ready, chg_valid);
        end
        if (busy === 1'b1) busy_cycles++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1; inst = 3'd1; ch = 2'd1; din = 8'hEE;
            @(posedge clk);
            #1;
            if (busy === 1'b1) busy_cycles++;
            tests++;
            if (chg_valid !== exp_pulse[i] || (exp_pulse[i] && chg_ch !== 2'(i)) ||
                busy !== (i < 3) || in_ready !== (i == 3)) begin
                fails++; $display("FAIL clr_step%0d: chg=%b chg_ch=%0d busy=%b in_ready=%b expected %b %0d %b %b",
                                  i, chg_valid, chg_ch, busy, in_ready, exp_pulse[i], i, i < 3, i == 3);
            end
        end
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin ml[k] = 8'h0; mr[k] = 8'h0; end
        tests++;
        if (q_l !== 32'h0 || q_r !== 32'h0 || busy_cycles != 4) begin
            fails++; $display("FAIL clr_done: q_l=%h q_r=%h busy_cycles=%0d expected 0 0 4", q_l, q_r, busy_cycles);
        end
    endtask

    task automatic test_range_err();
        send3(3'd1, 2'd1, 8'h3C);
        tests++;
        if (err3 !== 1'b0 || q_l3 !== 24'h003C00) begin
            fails++; $display("FAIL err_inrange: err=%b q_l=%h expected 0 003C00", err3, q_l3);
        end
        send3(3'd1, 2'd3, 8'hFF);
        tests++;
        if (err3 !== 1'b1 || q_l3 !== 24'h003C00 || q_r3 !== 24'h0 || chg_valid3 !== 1'b0) begin
            fails++; $display("FAIL err_pulse: err=%b q_l=%h q_r=%h chg=%b expected 1 003C00 0 0",
                              err3, q_l3, q_r3, chg_valid3);
        end
        @(posedge clk);
        #1;
        tests++;
        if (err3 !== 1'b0) begin
            fails++; $display("FAIL err_oneshot: err=%b expected 0", err3);
        end
        send3(3'd5, 2'd3, 8'h01);
        tests++;
        if (err3 !== 1'b1 || q_r3 !== 24'h0) begin
            fails++; $display("FAIL err_xorr: err=%b q_r=%h expected 1 0", err3, q_r3);
        end
        send3(3'd0, 2'd3, 8'h00);
        tests++;
        if (err3 !== 1'b0) begin
            fails++; $display("FAIL err_nop: err=%b expected 0", err3);
        end
    endtask

    task automatic test_reset_mid_sweep();
        logic ec;
        send(3'd1, 2'd3, 8'h99, 2'd0);
        send(3'd1, 2'd0, 8'h5A, 2'd0);
        send(3'd7, 2'd0, 8'h00, 2'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        tests++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || q_l !== 32'h0 || q_r !== 32'h0) begin
            fails++; $display("FAIL midrst_state: busy=%b in_ready=%b q_l=%h q_r=%h expected 0 1 0 0",
                              busy, in_ready, q_l, q_r);
        end
        tests++;
        if (ltor_xor !== 8'h0 || chg_valid !== 1'b0 || chg_ch !== 2'd0 || err !== 1'b0) begin
            fails++; $display("FAIL midrst_outs: ltor=%h chg=%b chg_ch=%0d err=%b expected 0",
                              ltor_xor, chg_valid, chg_ch, err);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin ml[k] = 8'h0; mr[k] = 8'h0; end
        model_apply(3'd2, 2'd1, 8'h01, ec);
        send(3'd2, 2'd1, 8'h01, 2'd0);
        tests++;
        if (q_r !== pack_r() || chg_valid !== ec || chg_ch !== 2'd1) begin
            fails++; $display("FAIL midrst_resume: q_r=%h chg=%b expected %h %b", q_r, chg_valid, pack_r(), ec);
        end
    endtask

    initial begin
        in_valid = 1'b0; inst = 3'd0; ch = 2'd0; din = 8'h0; rd_ch = 2'd0;
        in_valid3 = 1'b0; inst3 = 3'd0; ch3 = 2'd0; din3 = 8'h0; rd_ch3 = 2'd0;
        test_reset();
        test_set_readback();
        test_xorl();
        test_swap_setb();
        test_random();
        test_clrall();
        test_range_err();
        test_reset_mid_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
